// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared widths, arbiter state and response record for the
//               memory request controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int c_ADDR_W = 5;
    localparam int c_DATA_W = 32;

    typedef enum logic {
        LAST_WR = 1'b0,
        LAST_RD = 1'b1
    } arb_last_e;

    typedef struct packed {
        logic [c_DATA_W-1:0] data;
        logic                empty_tag;
    } rd_resp_t;

endpackage
`default_nettype wire

// File: rtl/mem_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp_fifo
// Description : Synchronous read-response FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_resp_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  rd_resp_t         push_data,
    input  logic             pop,
    output rd_resp_t         head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(DEPTH - 1);

    rd_resp_t           r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop;

    assign w_pop = pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                r_mem[r_wptr] <= push_data;
                r_wptr        <= (r_wptr == c_LAST_IDX) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_LAST_IDX) ? '0 : r_rptr + 1'b1;
            end
            case ({push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head       = r_mem[r_rptr];
    assign head_valid = (r_count != '0);
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_ctrl
// Description : Arbitrates write/read request channels onto a single memory
//               port and returns read data through a credit-protected FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int RESP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic              rd_resp_empty,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] data_out,
    input  logic              full,
    input  logic              empty,
    input  logic              half_full
);

    localparam int                 c_CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [c_CNT_W:0]   c_DEPTH = (c_CNT_W + 1)'(RESP_DEPTH);

    arb_last_e          r_last;
    logic               r_wr_en;
    logic               r_rd_en;
    logic               r_cap_vld;
    logic               r_tag_issue;
    logic               r_tag_cap;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wr_data;

    logic [c_CNT_W-1:0] w_fifo_count;
    logic [c_CNT_W:0]   w_used;
    logic               w_rd_elig;
    logic               w_contend;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_pop;
    rd_resp_t           w_push_data;
    rd_resp_t           w_head;
    logic               w_unused_status;

    // Credits = depth minus FIFO occupancy minus reads still in issue/capture.
    assign w_used    = {1'b0, w_fifo_count}
                     + {{c_CNT_W{1'b0}}, r_rd_en}
                     + {{c_CNT_W{1'b0}}, r_cap_vld};
    assign w_rd_elig = rd_req_valid && (w_used < c_DEPTH);
    assign w_contend = wr_req_valid && w_rd_elig;
    assign w_wr_acc  = rst_n && wr_req_valid && (!w_rd_elig || (r_last == LAST_RD));
    assign w_rd_acc  = rst_n && w_rd_elig && (!wr_req_valid || (r_last == LAST_WR));

    assign wr_req_ready = w_wr_acc;
    assign rd_req_ready = w_rd_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last      <= LAST_RD;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_cap_vld   <= 1'b0;
            r_tag_issue <= 1'b0;
            r_tag_cap   <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en   <= w_wr_acc;
            r_rd_en   <= w_rd_acc;
            r_cap_vld <= r_rd_en;
            r_tag_cap <= r_tag_issue;
            if (w_contend) begin
                r_last <= w_wr_acc ? LAST_WR : LAST_RD;
            end
            if (w_wr_acc) begin
                r_addr    <= wr_req_addr;
                r_wr_data <= wr_req_data;
            end else if (w_rd_acc) begin
                r_addr      <= rd_req_addr;
                r_tag_issue <= empty;
            end
        end
    end

    assign w_push_data.data      = data_out;
    assign w_push_data.empty_tag = r_tag_cap;
    assign w_pop                 = rd_resp_valid && rd_resp_ready;

    mem_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .CNT_W (c_CNT_W)
    ) u_resp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (r_cap_vld),
        .push_data  (w_push_data),
        .pop        (w_pop),
        .head       (w_head),
        .head_valid (rd_resp_valid),
        .count      (w_fifo_count)
    );

    assign rd_resp_data  = w_head.data;
    assign rd_resp_empty = w_head.empty_tag;

    assign wr_en   = r_wr_en;
    assign rd_en   = r_rd_en;
    assign addr    = r_addr;
    assign wr_data = r_wr_data;

    // Writes overwrite by address, so the fill-level flags never gate anything.
    assign w_unused_status = full ^ half_full;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_ctrl
// Description : Directed self-checking bench for mem_req_ctrl with a simple
//               32x32 memory model behind the port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req_valid, wr_req_ready;
    logic [4:0]  wr_req_addr;
    logic [31:0] wr_req_data;
    logic        rd_req_valid, rd_req_ready;
    logic [4:0]  rd_req_addr;
    logic        rd_resp_valid, rd_resp_ready;
    logic [31:0] rd_resp_data;
    logic        rd_resp_empty;
    logic        wr_en, rd_en;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] data_out;
    logic        full, empty, half_full;

    logic [31:0] tb_mem [32];

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int n_rd    = 0;

    always #5 clk = ~clk;

    mem_req_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .rd_resp_data  (rd_resp_data),
        .rd_resp_empty (rd_resp_empty),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .addr          (addr),
        .wr_data       (wr_data),
        .data_out      (data_out),
        .full          (full),
        .empty         (empty),
        .half_full     (half_full)
    );

    // Memory model: data_out is valid the cycle after rd_en.
    always @(posedge clk) begin
        if (wr_en) tb_mem[addr] <= wr_data;
        if (rd_en) data_out <= tb_mem[addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) tb_mem[i] = 32'h0;
        data_out      = 32'h0;
        full          = 1'b0;
        half_full     = 1'b0;
        empty         = 1'b1;
        rst_n         = 1'b0;
        wr_req_valid  = 1'b1;
        rd_req_valid  = 1'b1;
        wr_req_addr   = 5'd0;
        wr_req_data   = 32'h0;
        rd_req_addr   = 5'd0;
        rd_resp_ready = 1'b1;

        // Reset: readies held low, registered outputs cleared
        repeat (3) step();
        #1;
        chk("rst_wr_ready", wr_req_ready, 0);
        chk("rst_rd_ready", rd_req_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_resp_valid", rd_resp_valid, 0);
        chk("rst_resp_data", rd_resp_data, 0);
        chk("rst_resp_empty", rd_resp_empty, 0);
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;
        rst_n        = 1'b1;

        step(); #1;
        chk("idle_wr_en", wr_en, 0);
        chk("idle_rd_en", rd_en, 0);
        chk("idle_resp_valid", rd_resp_valid, 0);

        // First read of an empty memory: data 0, empty tag set, valid at N+3
        step(); rd_req_valid = 1'b1; rd_req_addr = 5'd3; #1;
        chk("t1_rd_ready", rd_req_ready, 1);
        chk("t1_wr_ready", wr_req_ready, 0);
        step(); rd_req_valid = 1'b0; #1;
        chk("t1_rd_en", rd_en, 1);
        chk("t1_addr", addr, 3);
        step(); #1;
        chk("t1_rd_en_off", rd_en, 0);
        chk("t1_valid_n2", rd_resp_valid, 0);
        step(); #1;
        chk("t1_valid_n3", rd_resp_valid, 1);
        chk("t1_data", rd_resp_data, 0);
        chk("t1_tag", rd_resp_empty, 1);
        step(); #1;
        chk("t1_popped", rd_resp_valid, 0);

        // Write then read the same address
        empty = 1'b0;
        step(); wr_req_valid = 1'b1; wr_req_addr = 5'd5; wr_req_data = 32'hDEADBEEF; #1;
        chk("t2_wr_ready", wr_req_ready, 1);
        step(); wr_req_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 5'd5; #1;
        chk("t2_rd_ready", rd_req_ready, 1);
        chk("t2_wr_en", wr_en, 1);
        chk("t2_wr_addr", addr, 5);
        chk("t2_wr_data", wr_data, 32'hDEADBEEF);
        step(); rd_req_valid = 1'b0; #1;
        chk("t2_rd_en", rd_en, 1);
        chk("t2_wr_en_off", wr_en, 0);
        chk("t2_rd_addr", addr, 5);
        step(); #1;
        step(); #1;
        chk("t2_valid", rd_resp_valid, 1);
        chk("t2_data", rd_resp_data, 32'hDEADBEEF);
        chk("t2_tag", rd_resp_empty, 0);
        step(); #1;
        chk("t2_popped", rd_resp_valid, 0);

        // Contention after a fresh reset: WR first, then strict alternation
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            wr_req_valid = 1'b1; rd_req_valid = 1'b1;
            wr_req_addr  = i[4:0];
            wr_req_data  = 32'h100 + 32'(i);
            rd_req_addr  = i[4:0];
            #1;
            chk("t3_wr_grant", wr_req_ready, (i % 2 == 0));
            chk("t3_rd_grant", rd_req_ready, (i % 2 == 1));
            if (wr_req_ready) n_wr++;
            if (rd_req_ready) n_rd++;
        end
        step(); wr_req_valid = 1'b0; rd_req_valid = 1'b0; #1;
        chk("t3_wr_count", n_wr, 4);
        chk("t3_rd_count", n_rd, 4);
        repeat (5) step();

        // Backpressure: four credits, then stall; drain in order
        rd_resp_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(); rd_req_valid = 1'b1; rd_req_addr = 5'(2 * k); #1;
            chk("t4_rd_ready", rd_req_ready, (k < 4));
        end
        step(); rd_req_valid = 1'b0; rd_resp_ready = 1'b1; #1;
        chk("t4_head_valid", rd_resp_valid, 1);
        chk("t4_head0", rd_resp_data, 32'h100);
        for (int j = 1; j < 4; j++) begin
            step(); #1;
            chk("t4_drain_valid", rd_resp_valid, 1);
            chk("t4_drain_data", rd_resp_data, 32'h100 + 32'(2 * j));
        end
        step(); rd_req_valid = 1'b1; rd_req_addr = 5'd5; #1;
        chk("t4_drained", rd_resp_valid, 0);
        chk("t4_resume", rd_req_ready, 1);
        step(); rd_req_valid = 1'b0;
        repeat (5) step();

        // Full-rate streaming: fill memory, then 32 back-to-back reads
        for (int i = 0; i < 32; i++) begin
            step(); wr_req_valid = 1'b1; wr_req_addr = i[4:0]; wr_req_data = 32'hA500_0000 | 32'(i); #1;
            chk("t5_wr_ready", wr_req_ready, 1);
        end
        step(); wr_req_valid = 1'b0;
        for (int k = 0; k < 35; k++) begin
            step();
            rd_req_valid = (k < 32);
            rd_req_addr  = k[4:0];
            #1;
            if (k < 32) chk("t5_rd_ready", rd_req_ready, 1);
            if (k >= 3) begin
                chk("t5_valid", rd_resp_valid, 1);
                chk("t5_data", rd_resp_data, 32'hA500_0000 | 32'(k - 3));
            end
        end
        step(); #1;
        chk("t5_done", rd_resp_valid, 0);

        // Reset with two reads in flight and two held in the FIFO
        rd_resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(); rd_req_valid = 1'b1; rd_req_addr = k[4:0]; #1;
            chk("t6_fill_ready", rd_req_ready, 1);
        end
        step(); rd_req_valid = 1'b0; rst_n = 1'b0; #1;
        chk("t6_pre_valid", rd_resp_valid, 1);
        chk("t6_rst_ready", rd_req_ready, 0);
        step(); rst_n = 1'b1; rd_resp_ready = 1'b1; #1;
        chk("t6_post_valid", rd_resp_valid, 0);
        chk("t6_post_rd_en", rd_en, 0);
        for (int k = 0; k < 5; k++) begin
            step(); #1;
            chk("t6_no_stale", rd_resp_valid, 0);
        end
        rd_resp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(); rd_req_valid = 1'b1; rd_req_addr = k[4:0]; #1;
            chk("t6_credits", rd_req_ready, (k < 4));
        end
        step(); rd_req_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
